replace_plru: RTL
=================

# replace_plru

Parametrised per-set cache replacement engine: a successor to the single-port replacement interface, supporting multiple hit-update ports, an explicit allocate strobe, flush, and a selectable policy. Each set keeps tree-PLRU state (MODE=0), or the engine uses a shared LFSR (MODE=1). It serves ICache, DCache and TLB arrays. It sits beside the tag array: lookup pipelines report hits, and the miss/refill path reads the victim way and commits the allocation.

## Interface
- DEPTH, 256, number of sets (≥1)
- WAY_NUM, 4, associativity (power of two, 2..16)
- READ_PORT, 1, number of hit-update ports (≥1)
- MODE, 0, 0 = tree-PLRU, 1 = LFSR pseudo-random
- WAY_WIDTH, $clog2(WAY_NUM), derived
- ADDR_WIDTH, DEPTH<=1 ? 1 : $clog2(DEPTH), derived
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- hit_en  input  READ_PORT  per-port access strobe
- hit_way  input  READ_PORT×WAY_WIDTH  way accessed on that port
- hit_index  input  READ_PORT×ADDR_WIDTH  set accessed on that port
- miss_index  input  ADDR_WIDTH  set being allocated
- miss_en  input  1  allocation commit; the current miss_way is marked accessed
- flush  input  1  synchronous clear of all replacement state
- miss_way  output  WAY_WIDTH  victim way for miss_index

## Operation
- **State, MODE=0:** DEPTH × (WAY_NUM-1) tree bits.
  - Node 0 is the root; node i has children 2i+1 and 2i+2.
  - Leaves map to ways 0..WAY_NUM-1, left to right.
- **Victim walk:** start at the root of set miss_index. Bit 0 goes to the left child, bit 1 goes to the right child. The leaf reached is miss_way.
- **Access update, way w:** every node on the path to w is set to point away from w.
  - w in the left subtree: node = 1.
  - w in the right subtree: node = 0.
  - Nodes off the path are unchanged.
- **Update ordering within one cycle:**
  - Hit ports are applied sequentially, port 0 first, then port READ_PORT-1.
  - The miss_en update (way = miss_way, set = miss_index) is applied last.
  - When updates overlap on the same set's nodes, the later one wins per node. Non-overlapping nodes from all updates are all kept.
- **hit_en:** hit_way and hit_index are ignored when the port's hit_en is 0.
- **MODE=1:**
  - No per-set state; one 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - miss_way = lfsr[WAY_WIDTH-1:0].
  - The LFSR shifts one step on each cycle with miss_en=1.
  - Hits are ignored.
- **flush:**
  - Clears all tree bits to 0 and reseeds the LFSR to 16'h0001.
  - It has priority over all same-cycle hit and miss updates, which are dropped.
- **Reset (rst=0):** all tree bits 0 and LFSR = 16'h0001.
  - miss_way reset value: 0 in MODE=0; 1 (WAY_WIDTH≥1) in MODE=1.
- **DEPTH=1:** the index inputs are ignored; set 0 is always used.

## Timing
- **miss_way latency:** combinational from miss_index and the registered state, with zero latency.
- **Update visibility:** updates from cycle N are visible on miss_way in cycle N+1. A same-cycle hit does not affect miss_way in that cycle.
- **miss_en:** one pulse per allocation. Consecutive-cycle miss_en to the same set returns a fresh victim each cycle.
- **Throughput:** no handshake and no stall; READ_PORT hits plus one allocation are accepted every cycle.
- **Reset mid-operation:** asynchronous assertion immediately forces state and miss_way to reset values. Deassertion is synchronised externally.

## Test plan
- **Reset:** MODE=0, 4-way; release reset -> miss_way=0 for every miss_index.
- **Hit sequence:** MODE=0, 4-way, set 5.
  - Hit way 0 -> next cycle miss_way=2.
  - Then hit way 2 -> miss_way=1.
  - Then hit way 1 -> miss_way=3.
  - Set 6 stays at miss_way=0 throughout.
- **Multi-port ordering:** READ_PORT=2, set 3, same cycle port0 hits way 0 and port1 hits way 1 -> root=1 and node1=0 -> miss_way=2.
  - Swapped (port0 way 1, port1 way 0) -> node1=1 -> miss_way=2, with internal node1 differing (check via a subsequent hit on way 2 -> miss_way 1 vs 0).
- **Allocate and flush:**
  - miss_en on set 7 at reset state -> way 0 marked accessed -> next miss_way=2.
  - flush together with a hit in the same cycle -> next cycle all sets miss_way=0.
- **LFSR:** MODE=1, 8-way; reset -> miss_way=1.
  - Pulse miss_en 16 times -> miss_way follows the reference LFSR low 3 bits each step.
  - Hits do not change the sequence.
- **Async reset:** assert rst=0 mid-run after updates -> miss_way returns to 0 before the next clock edge.

Source files
------------

// File: rtl/replace_plru.sv
// Per-set replacement engine: tree-PLRU per set (MODE=0) or shared 16-bit LFSR (MODE=1).
// Latency: miss_way is combinational from miss_index and state; updates visible next cycle.
// Backpressure: none; READ_PORT hits plus one allocation accepted every cycle, flush wins.
module replace_plru #(
  parameter int DEPTH      = 256,
  parameter int WAY_NUM    = 4,
  parameter int READ_PORT  = 1,
  parameter int MODE       = 0,
  parameter int WAY_WIDTH  = $clog2(WAY_NUM),
  parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORT-1:0]                  hit_en,
  input  logic [READ_PORT-1:0][WAY_WIDTH-1:0]   hit_way,
  input  logic [READ_PORT-1:0][ADDR_WIDTH-1:0]  hit_index,
  input  logic [ADDR_WIDTH-1:0]                 miss_index,
  input  logic                                  miss_en,
  input  logic                                  flush,
  output logic [WAY_WIDTH-1:0]                  miss_way
);

  localparam int NODES = WAY_NUM - 1;

  // A single-set array has no meaningful index; always use set 0.
  function automatic logic [ADDR_WIDTH-1:0] set_sel(input logic [ADDR_WIDTH-1:0] idx);
    return (DEPTH == 1) ? '0 : idx;
  endfunction

  if (MODE == 0) begin : g_plru

    logic [DEPTH-1:0][NODES-1:0] tree_q, tree_d;
    logic [ADDR_WIDTH-1:0]       miss_set;

    // Walk from the root: a 0 bit steps left, a 1 bit steps right; the leaf is the victim.
    // Nodes are matched by comparison so the walk never needs a computed bit-select.
    function automatic logic [WAY_WIDTH-1:0] victim(input logic [NODES-1:0] row);
      int   node;
      logic b;
      node = 0;
      for (int l = 0; l < WAY_WIDTH; l++) begin
        b = 1'b0;
        for (int n = 0; n < NODES; n++) begin
          if (n == node) b = row[n];
        end
        node = 2 * node + 1 + int'(b);
      end
      return WAY_WIDTH'(node - NODES);
    endfunction

    // Point every node on the path to 'way' away from it; off-path nodes are untouched.
    function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] row,
                                               input logic [WAY_WIDTH-1:0] way);
      logic [NODES-1:0] r;
      int               path;
      int               dir;
      r = row;
      for (int l = 0; l < WAY_WIDTH; l++) begin
        path = (1 << l) - 1 + (int'(way) >> (WAY_WIDTH - l));
        dir  = (int'(way) >> (WAY_WIDTH - 1 - l)) & 1;
        for (int n = 0; n < NODES; n++) begin
          if (n == path) r[n] = (dir == 0);
        end
      end
      return r;
    endfunction

    // Victim lookup straight off the registered tree of the miss set.
    always_comb begin
      miss_set = set_sel(miss_index);
      miss_way = victim(tree_q[miss_set]);
    end

    // Apply hits in port order, then the allocation, so later updates win per node.
    always_comb begin
      tree_d = tree_q;
      if (flush) begin
        tree_d = '0;
      end else begin
        for (int p = 0; p < READ_PORT; p++) begin
          if (hit_en[p]) begin
            tree_d[set_sel(hit_index[p])] = touch(tree_d[set_sel(hit_index[p])], hit_way[p]);
          end
        end
        if (miss_en) begin
          tree_d[miss_set] = touch(tree_d[miss_set], miss_way);
        end
      end
    end

    // Tree state register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) tree_q <= '0;
      else      tree_q <= tree_d;
    end

  end else begin : g_lfsr

    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; steps once per allocation, flush reseeds.
    always_comb begin
      lfsr_d = lfsr_q;
      if (flush) begin
        lfsr_d = 16'h0001;
      end else if (miss_en) begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
      miss_way = lfsr_q[WAY_WIDTH-1:0];
    end

    // LFSR register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= 16'h0001;
      else      lfsr_q <= lfsr_d;
    end

  end

endmodule
